mac_stream_writer: RTL
======================

# mac_stream_writer

Stream-side counterpart of the MAC comparator: serialises a 48-bit MAC address into the sniffer's 32-bit word stream at any of the four byte alignments, with configurable leading fill words. It drives comparator and sniffer benches and the loopback self-test path, and emits exactly the byte layout the comparator is built to detect. Output uses a valid/ready handshake, so downstream back-pressure is honoured.

## Interface
Parameters:
- MAX_PRE, 15: largest leading-fill word count accepted; sets the width of `pre_words`.

Ports:
- clk  in  1  system clock; all activity on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request, sampled only in IDLE.
- mac_in  in  48  MAC address, MSB byte first (for example 48'hA1B2C3D4E5F6).
- lane  in  2  byte lane (0-3) of the MAC's least-significant byte within the first MAC word.
- fill  in  8  pad byte used for all non-MAC bytes.
- pre_words  in  4  number of all-fill words sent before the MAC words (0..MAX_PRE).
- ready  in  1  downstream accepts `data_out` this cycle.
- data_out  out  32  stream word.
- valid  out  1  `data_out` is meaningful.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Stream layout: word k is more significant than word k-1. The image {w2,w1,w0} is 96 bits, with the MAC at bits [8*lane+47 : 8*lane]. All other bytes equal `fill`.
- MAC word count: 2 when `lane` is 0-2, 3 when `lane` is 3.
- On an accepted start, `mac_in`, `lane`, `fill` and `pre_words` are latched. Later changes to these inputs have no effect until the next start.
- The 96-bit image is built at start. Each accepted MAC beat shifts it right by 32 bits.
- State IDLE: `valid`=0, `busy`=0. With `start`=1, go to PRE if `pre_words`≠0, otherwise go to MAC. The pre counter is loaded with `pre_words`.
- State PRE: `data_out`={4{fill}}, `valid`=1. On each transfer (`valid`&&`ready`) the counter decrements. The transfer that brings it to 0 moves the state to MAC.
- State MAC: `data_out`=image[31:0], `valid`=1. A word counter is loaded with 2 or 3. The last transfer moves the state to DONE.
- State DONE: `valid`=0, `done`=1, `busy`=1 for exactly one cycle, then IDLE.
- Back-pressure: while `valid`=1 and `ready`=0, `data_out` and state hold stable. `data_out` never changes without a transfer.
- `start` in any state other than IDLE is ignored. `start` during DONE is ignored. It may be reasserted once IDLE is reached.
- `rst`=1 has priority over everything. At the next edge the block goes to IDLE, and the partial stream is abandoned with no `done` pulse.
- When `valid`=0, `data_out` shows the last value or 0. It is don't-care for checking, except that reset forces 0.

## Timing
- Reset values: `data_out`=32'h0, `valid`=0, `busy`=0, `done`=0. Internal counters and image are cleared.
- Latency: start sampled at edge N puts the first word on `data_out` with `valid`=1 after edge N.
- With `ready` held high, one word transfers per cycle. The total stream is `pre_words` + (2 or 3) cycles, followed by `done` in the next cycle.
- Start-to-start minimum, with `ready`=1: `pre_words` + nwords + 2 cycles (includes DONE and IDLE).
- `ready` is not registered internally. A transfer occurs at any edge with `valid`&&`ready`.
- If `rst` and `start` are both asserted at the same edge, reset wins.
- `pre_words`=0 skips PRE entirely. PRE is never entered with a count of 0.

## Test plan
- Lane 2, `pre_words`=0, `mac_in`=A1B2C3D4E5F6, `fill`=00, `ready`=1 → words E5F60000, A1B2C3D4; `done` one cycle later; `busy` then falls.
- Lane 1 → D4E5F600, 00A1B2C3. Lane 0 → C3D4E5F6, 0000A1B2. Lane 3 → F6000000, B2C3D4E5, 000000A1 (3 beats).
- Lane 0 with `ready` toggling 1,0,0,1 → first word held at C3D4E5F6 through the stall cycles, with no duplicate or skipped word; `done` only after 0000A1B2 is accepted.
- `pre_words`=2, `fill`=AA, lane 1 → AAAAAAAA, AAAAAAAA, D4E5F6AA, AAA1B2C3.
- `start` pulsed mid-stream, and `mac_in` changed mid-stream → stream unaffected; a single `done`. `rst` asserted after the first word → next cycle all outputs at reset values, no `done`; a new start then produces a clean full stream.
- Loopback: `data_out` fed into the MAC comparator (cleared first, same `mac_in`, `fill`=00) for each lane → comparator `match` asserts after the final MAC word.

Source files
------------

// File: rtl/mac_stream_writer.sv
// rtl/mac_stream_writer.sv - serialises a 48-bit MAC into a 32-bit word stream with leading fill words
module mac_stream_writer #(
    parameter int MAX_PRE = 15,
    localparam int PW = $clog2(MAX_PRE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [47:0]   mac_in,
    input  logic [1:0]    lane,
    input  logic [7:0]    fill,
    input  logic [PW-1:0] pre_words,
    input  logic          ready,
    output logic [31:0]   data_out,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [95:0]   image_q;
    logic [95:0]   image_d;
    logic [PW-1:0] pre_cnt_q;
    logic [1:0]    word_cnt_q;
    logic [1:0]    nwords_d;
    logic [31:0]   data_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    // Build the three-word image from the live inputs; only captured when a start is accepted
    always_comb begin
        image_d  = {12{fill}};
        nwords_d = 2'd2;
        case (lane)
            2'd0: image_d = {{6{fill}}, mac_in};
            2'd1: image_d = {{5{fill}}, mac_in, fill};
            2'd2: image_d = {{4{fill}}, mac_in, {2{fill}}};
            2'd3: begin
                image_d  = {{3{fill}}, mac_in, {3{fill}}};
                nwords_d = 2'd3;
            end
            default: image_d = {12{fill}};
        endcase
    end

    // Sequencer: IDLE -> (PRE) -> MAC -> DONE -> IDLE, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            image_q    <= '0;
            pre_cnt_q  <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        image_q    <= image_d;
                        word_cnt_q <= nwords_d;
                        pre_cnt_q  <= pre_words;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        if (pre_words != '0) begin
                            data_q  <= {4{fill}};
                            state_q <= ST_PRE;
                        end else begin
                            data_q  <= image_d[31:0];
                            state_q <= ST_MAC;
                        end
                    end
                end
                ST_PRE: begin
                    // Fill word is already on data_q; it stays there until the last pre transfer
                    if (ready) begin
                        pre_cnt_q <= pre_cnt_q - PW'(1);
                        if (pre_cnt_q == PW'(1)) begin
                            data_q  <= image_q[31:0];
                            state_q <= ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    if (ready) begin
                        image_q    <= image_q >> 32;
                        word_cnt_q <= word_cnt_q - 2'd1;
                        if (word_cnt_q == 2'd1) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            data_q <= image_q[63:32];
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
